// File: rtl/complex_dot_product_stream_pkg.sv
// Shared types and helpers for the streaming complex dot-product engine.
// Holds the FSM encoding, drain depth and the lane/length/saturation helpers.
package complex_dp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPass,
    StDrain,
    StDone
  } state_e;

  // Multiplier register, lane adder-tree register, accumulate.
  localparam int unsigned DRAIN_CYCLES = 3;

  // Bit offset of a lane within a packed row; lane 0 sits at the MSBs.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned elem_w,
                                           input int unsigned lanes);
    return (lanes - 1 - lane) * elem_w;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Clip a signed value to the w-bit two's complement range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/complex_dot_product_stream_if.sv
// Handshake bundle of the dot-product engine: start/length, operand beats and result.
// The master side is the row-reader/solver; the slave side is the engine.
interface complex_dot_product_stream_if #(
  parameter int unsigned COMP_W = 16,
  parameter int unsigned NI     = 8,
  parameter int unsigned LEN_W  = 12
);

  logic                     start;
  logic                     start_ready;
  logic [LEN_W-1:0]         len;
  logic                     conj_en;
  logic                     in_valid;
  logic                     in_ready;
  logic [2*COMP_W*NI-1:0]   a_row;
  logic [2*COMP_W*NI-1:0]   b_row;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [COMP_W-1:0] dot_re;
  logic signed [COMP_W-1:0] dot_im;
  logic                     sat;

  modport master (
    output start, len, conj_en, in_valid, a_row, b_row, out_ready,
    input  start_ready, in_ready, out_valid, dot_re, dot_im, sat
  );

  modport slave (
    input  start, len, conj_en, in_valid, a_row, b_row, out_ready,
    output start_ready, in_ready, out_valid, dot_re, dot_im, sat
  );

endinterface

// File: rtl/complex_dot_product_stream_mac_lane.sv
// One complex multiplier with optional conjugation of operand A and registered
// full-precision outputs (2*COMP_W+1 bits per component).
module complex_mac_lane #(
  parameter int unsigned COMP_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     conj,
  input  logic signed [COMP_W-1:0] ar,
  input  logic signed [COMP_W-1:0] ai,
  input  logic signed [COMP_W-1:0] br,
  input  logic signed [COMP_W-1:0] bi,
  output logic signed [2*COMP_W:0] re,
  output logic signed [2*COMP_W:0] im
);

  localparam int unsigned PW = 2 * COMP_W + 1;

  logic signed [COMP_W:0] ai_w;
  logic signed [COMP_W:0] ai_c;
  logic signed [PW-1:0]   ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0]   p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]   re_q, im_q;

  // Negation happens one bit wider so that -(-2^(COMP_W-1)) does not wrap.
  always_comb begin
    ai_w = {ai[COMP_W-1], ai};
    ai_c = conj ? -ai_w : ai_w;
    ar_x = PW'(ar);
    ai_x = PW'(ai_c);
    br_x = PW'(br);
    bi_x = PW'(bi);
    p_rr = ar_x * br_x;
    p_ii = ai_x * bi_x;
    p_ri = ar_x * bi_x;
    p_ir = ai_x * br_x;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      re_q <= '0;
      im_q <= '0;
    end else if (en) begin
      re_q <= p_rr - p_ii;
      im_q <= p_ri + p_ir;
    end
  end

  assign re = re_q;
  assign im = im_q;

endmodule

// File: rtl/complex_dot_product_stream.sv
// Streaming complex dot-product: NI-lane beats, MULS multipliers time-multiplexed
// over NI/MULS passes, lane adder tree, wrapping accumulator and saturated output.
module complex_dot_product_stream
  import complex_dp_pkg::*;
#(
  parameter int unsigned COMP_W = 16,
  parameter int unsigned NI     = 8,
  parameter int unsigned MULS   = 4,
  parameter int unsigned LEN_W  = 12,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned FRAC   = 8
) (
  input logic                  clk,
  input logic                  reset,
  complex_dot_product_stream_if.slave bus
);

  localparam int unsigned EW     = 2 * COMP_W;
  localparam int unsigned PW     = 2 * COMP_W + 1;
  localparam int unsigned P      = NI / MULS;
  localparam int unsigned PASS_W = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned BEAT_W = LEN_W + 1;
  localparam int unsigned ROW_W  = EW * NI;
  localparam int unsigned ROW_IW = $clog2(ROW_W);

  state_e state_q, state_d;

  logic                     armed_q;
  logic [LEN_W-1:0]         len_q;
  logic                     conj_q;
  logic [BEAT_W-1:0]        num_beats_q;
  logic [BEAT_W-1:0]        beat_idx_q;
  logic [PASS_W-1:0]        pass_q;
  logic [1:0]               drain_cnt_q;
  logic [ROW_W-1:0]         a_q, b_q;
  logic                     mul_valid_q, tree_valid_q;
  logic signed [ACC_W-1:0]  tree_re_d, tree_im_d, tree_re_q, tree_im_q;
  logic signed [ACC_W-1:0]  acc_re_q, acc_im_q;
  logic signed [COMP_W-1:0] dot_re_q, dot_im_q;
  logic                     sat_q;

  logic start_ready, in_ready, out_valid;
  logic start_fire, in_fire, out_fire;
  logic last_pass, more_beats, drain_last;

  logic signed [PW-1:0] mul_re [MULS];
  logic signed [PW-1:0] mul_im [MULS];

  assign start_fire = bus.start & start_ready;
  assign in_fire    = bus.in_valid & in_ready;
  assign out_fire   = out_valid & bus.out_ready;
  assign last_pass  = (pass_q == PASS_W'(P - 1));
  assign more_beats = ((beat_idx_q + BEAT_W'(1)) < num_beats_q);
  assign drain_last = (drain_cnt_q == 2'(DRAIN_CYCLES - 1));

  // FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_fire) state_d = (bus.len == '0) ? StDone : StLoad;
      StLoad:  if (in_fire) state_d = StPass;
      StPass:  if (last_pass) state_d = more_beats ? StLoad : StDrain;
      StDrain: if (drain_last) state_d = StDone;
      StDone:  if (out_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. start_ready stays low until the first clock after reset release.
  always_comb begin
    start_ready = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (state_q)
      StIdle:  start_ready = armed_q;
      StLoad:  in_ready    = 1'b1;
      StDone:  out_valid   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q     <= 1'b0;
      len_q       <= '0;
      conj_q      <= 1'b0;
      num_beats_q <= '0;
      beat_idx_q  <= '0;
      pass_q      <= '0;
      drain_cnt_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      armed_q <= 1'b1;
      if (start_fire) begin
        len_q       <= bus.len;
        conj_q      <= bus.conj_en;
        num_beats_q <= BEAT_W'(ceil_div(32'(bus.len), NI));
        beat_idx_q  <= '0;
      end
      if (in_fire) begin
        a_q    <= bus.a_row;
        b_q    <= bus.b_row;
        pass_q <= '0;
      end
      if (state_q == StPass) begin
        if (last_pass) begin
          pass_q     <= '0;
          beat_idx_q <= beat_idx_q + BEAT_W'(1);
        end else begin
          pass_q <= pass_q + PASS_W'(1);
        end
      end
      drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 2'd1 : 2'd0;
    end
  end

  for (genvar m = 0; m < MULS; m++) begin : g_lane
    int unsigned              lane;
    int unsigned              gidx;
    logic                     live;
    logic [EW-1:0]            a_el, b_el;
    logic signed [COMP_W-1:0] ar, ai, br, bi;

    // Lanes past the runtime length are fed zeros so they add exactly nothing.
    always_comb begin
      lane = 32'(pass_q) * MULS + m;
      gidx = 32'(beat_idx_q) * NI + lane;
      live = (gidx < 32'(len_q));
      a_el = a_q[ROW_IW'(lane_lsb(lane, EW, NI)) +: EW];
      b_el = b_q[ROW_IW'(lane_lsb(lane, EW, NI)) +: EW];
      ar   = live ? a_el[EW-1 -: COMP_W] : '0;
      ai   = live ? a_el[COMP_W-1:0]     : '0;
      br   = live ? b_el[EW-1 -: COMP_W] : '0;
      bi   = live ? b_el[COMP_W-1:0]     : '0;
    end

    complex_mac_lane #(
      .COMP_W(COMP_W)
    ) u_mac (
      .clk  (clk),
      .reset(reset),
      .en   (state_q == StPass),
      .conj (conj_q),
      .ar   (ar),
      .ai   (ai),
      .br   (br),
      .bi   (bi),
      .re   (mul_re[m]),
      .im   (mul_im[m])
    );
  end

  always_comb begin
    tree_re_d = '0;
    tree_im_d = '0;
    for (int unsigned m = 0; m < MULS; m++) begin
      tree_re_d = tree_re_d + ACC_W'(mul_re[m]);
      tree_im_d = tree_im_d + ACC_W'(mul_im[m]);
    end
  end

  logic signed [ACC_W-1:0] sh_re, sh_im;
  logic signed [63:0]      ext_re, ext_im, clip_re, clip_im;

  always_comb begin
    sh_re   = acc_re_q >>> FRAC;
    sh_im   = acc_im_q >>> FRAC;
    ext_re  = 64'(sh_re);
    ext_im  = 64'(sh_im);
    clip_re = saturate(ext_re, COMP_W);
    clip_im = saturate(ext_im, COMP_W);
  end

  // Pipeline valids flow independently of the FSM so earlier beats keep
  // accumulating while the next beat is being loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_valid_q  <= 1'b0;
      tree_valid_q <= 1'b0;
      tree_re_q    <= '0;
      tree_im_q    <= '0;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      dot_re_q     <= '0;
      dot_im_q     <= '0;
      sat_q        <= 1'b0;
    end else begin
      mul_valid_q  <= (state_q == StPass);
      tree_valid_q <= mul_valid_q;
      if (mul_valid_q) begin
        tree_re_q <= tree_re_d;
        tree_im_q <= tree_im_d;
      end
      if (start_fire) begin
        acc_re_q <= '0;
        acc_im_q <= '0;
        dot_re_q <= '0;
        dot_im_q <= '0;
        sat_q    <= 1'b0;
      end else begin
        if (tree_valid_q) begin
          acc_re_q <= acc_re_q + tree_re_q;
          acc_im_q <= acc_im_q + tree_im_q;
        end
        if (state_q == StDrain && drain_last) begin
          dot_re_q <= COMP_W'(clip_re);
          dot_im_q <= COMP_W'(clip_im);
          sat_q    <= (clip_re != ext_re) | (clip_im != ext_im);
        end
      end
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.dot_re      = dot_re_q;
  assign bus.dot_im      = dot_im_q;
  assign bus.sat         = sat_q;

endmodule

// File: tb/tb_complex_dot_product_stream.sv
// Self-checking bench for complex_dot_product_stream: table-driven operations with a
// scoreboard queue plus hand-written reset, len=0, back-pressure and abort sequences.
module tb_complex_dot_product_stream;

  localparam int unsigned COMP_W  = 16;
  localparam int unsigned NI      = 8;
  localparam int unsigned MULS    = 4;
  localparam int unsigned LEN_W   = 12;
  localparam int unsigned ACC_W   = 48;
  localparam int unsigned FRAC    = 0;
  localparam int unsigned EW      = 2 * COMP_W;
  localparam int          TIMEOUT = 100;
  localparam int          NVEC    = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  complex_dot_product_stream_if #(.COMP_W(COMP_W), .NI(NI), .LEN_W(LEN_W)) bus ();

  complex_dot_product_stream #(
    .COMP_W(COMP_W),
    .NI    (NI),
    .MULS  (MULS),
    .LEN_W (LEN_W),
    .ACC_W (ACC_W),
    .FRAC  (FRAC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int len;
    bit conj;
    int ar, ai, br, bi;      // value of every in-range element
    int tar, tai, tbr, tbi;  // value of every lane past len
    int exp_re, exp_im;
    bit exp_sat;
  } vec_t;

  typedef struct {
    int re;
    int im;
    int sat;
  } exp_t;

  exp_t            sb_q[$];
  vec_t            vecs[NVEC];
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [EW*NI-1:0] a_row_v, b_row_v;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic give_up(input string what);
    n_fail++;
    $display("FAIL %s: timed out", what);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "bench stopped early");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " start_ready"}, int'(bus.start_ready), 0);
    check({tag, " in_ready"}, int'(bus.in_ready), 0);
    check({tag, " out_valid"}, int'(bus.out_valid), 0);
    check({tag, " dot_re"}, int'(bus.dot_re), 0);
    check({tag, " dot_im"}, int'(bus.dot_im), 0);
    check({tag, " sat"}, int'(bus.sat), 0);
  endtask

  // Lane 0 is shifted in first so it ends up at the MSBs.
  task automatic build_rows(input vec_t v, input int beat);
    logic [EW-1:0] ea, eb;
    for (int l = 0; l < int'(NI); l++) begin
      if (beat * int'(NI) + l < v.len) begin
        ea = {COMP_W'(v.ar), COMP_W'(v.ai)};
        eb = {COMP_W'(v.br), COMP_W'(v.bi)};
      end else begin
        ea = {COMP_W'(v.tar), COMP_W'(v.tai)};
        eb = {COMP_W'(v.tbr), COMP_W'(v.tbi)};
      end
      a_row_v = {a_row_v[EW*(NI-1)-1:0], ea};
      b_row_v = {b_row_v[EW*(NI-1)-1:0], eb};
    end
  endtask

  task automatic do_start(input int len, input bit conj);
    int n = 0;
    while (!bus.start_ready) begin
      @(negedge clk);
      n++;
      if (n > TIMEOUT) give_up("start_ready wait");
    end
    bus.len     = LEN_W'(len);
    bus.conj_en = conj;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic do_beat();
    int n = 0;
    bus.a_row    = a_row_v;
    bus.b_row    = b_row_v;
    bus.in_valid = 1'b1;
    while (!bus.in_ready) begin
      @(negedge clk);
      n++;
      if (n > TIMEOUT) give_up("in_ready wait");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts cycles until out_valid, optionally back-pressures, then scores the result.
  task automatic wait_result(input string tag, input int exp_lat, input int stall,
                             input vec_t v);
    int   n = 0;
    exp_t e;
    while (!bus.out_valid) begin
      @(negedge clk);
      n++;
      if (n > TIMEOUT) give_up({tag, " out_valid wait"});
    end
    check({tag, " latency"}, n, exp_lat);
    for (int s = 0; s < stall; s++) begin
      bus.start = 1'b1;
      bus.len   = LEN_W'(8);
      @(negedge clk);
      check({tag, " stall out_valid"}, int'(bus.out_valid), 1);
      check({tag, " stall start_ready"}, int'(bus.start_ready), 0);
      check({tag, " stall dot_re"}, int'(bus.dot_re), v.exp_re);
      check({tag, " stall sat"}, int'(bus.sat), int'(v.exp_sat));
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, " scoreboard depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, " dot_re"}, int'(bus.dot_re), e.re);
      check({tag, " dot_im"}, int'(bus.dot_im), e.im);
      check({tag, " sat"}, int'(bus.sat), e.sat);
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int stall);
    int nb;
    do_start(v.len, v.conj);
    sb_q.push_back('{v.exp_re, v.exp_im, int'(v.exp_sat)});
    nb = (v.len + int'(NI) - 1) / int'(NI);
    if (nb == 0) begin
      check({tag, " in_ready after start"}, int'(bus.in_ready), 0);
      wait_result(tag, 0, stall, v);
    end else begin
      for (int b = 0; b < nb; b++) begin
        build_rows(v, b);
        do_beat();
      end
      // Last handshake edge -> 2 PASS, 3 DRAIN, then DONE.
      wait_result(tag, 5, stall, v);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t abort_v;
    //            len  cj   ar      ai     br     bi   tar   tai  tbr  tbi  exp_re  exp_im sat
    vecs[0] = '{   8, 1'b0,      1,      2,     3,   4,    9,    9,   9,   9,    -40,     80, 1'b0};
    vecs[1] = '{   8, 1'b1,      1,      2,     3,   4,    9,    9,   9,   9,     88,    -16, 1'b0};
    vecs[2] = '{  13, 1'b0,      1,      0,     1,   0,  100,  100, 100, 100,     13,      0, 1'b0};
    vecs[3] = '{   5, 1'b0,      2,     -3,     4,   1,   -7,    5,   3,  -2,     55,    -50, 1'b0};
    vecs[4] = '{   8, 1'b0,  32767,      0, 32767,   0,    0,    0,   0,   0,  32767,      0, 1'b1};
    vecs[5] = '{   3, 1'b0, -32768,      0, 32767,   0, 1000, 1000,1000,1000, -32768,      0, 1'b1};
    vecs[6] = '{  20, 1'b1,     -1,      1,     2,   3,   50,  -50,  50,  50,     20,   -100, 1'b0};
    vecs[7] = '{   1, 1'b1,      0, -32768,     0,   1,    5,    5,   5,   5, -32768,      0, 1'b0};
    vecs[8] = '{4095, 1'b0,      1,      1,     1,  -1,    3,    3,   3,   3,   8190,      0, 1'b0};
    vecs[9] = '{   2, 1'b0,      0,  30000, 30000,   0,    7,    7,   7,   7,      0,  32767, 1'b1};
    abort_v = '{  24, 1'b0,     50,     50,    50,  50,   50,   50,  50,  50,      0,      0, 1'b0};

    bus.start     = 1'b0;
    bus.len       = '0;
    bus.conj_en   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_row     = '0;
    bus.b_row     = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check("idle start_ready", int'(bus.start_ready), 1);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 0);
    end

    // len = 0 completes without any beat.
    begin
      vec_t z;
      z = '{0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0};
      run_vec(z, "len0", 0);
      check("len0 in_ready idle", int'(bus.in_ready), 0);
    end

    // Saturated result held under back-pressure; start during DONE is ignored.
    bus.out_ready = 1'b0;
    run_vec(vecs[4], "stall", 5);
    check("post-stall start_ready", int'(bus.start_ready), 1);
    check("post-stall in_ready", int'(bus.in_ready), 0);
    check("post-stall out_valid", int'(bus.out_valid), 0);

    // Abort during PASS of beat 2 of 3, then a clean operation.
    do_start(abort_v.len, abort_v.conj);
    build_rows(abort_v, 0);
    do_beat();
    build_rows(abort_v, 1);
    do_beat();
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], "after-abort", 0);

    check("scoreboard empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
